uart_rx: RTL
============

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 521, clk cycles per bit (10 MHz / 19200 baud).
REQ-002 Parameter HALF_BIT, default CLKS_PER_BIT/2 (260), cycles from start-edge detection to mid-start sample.
REQ-003 clk  input  1  single clock; all flops rise-edge triggered.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 rx_in  input  1  serial line, asynchronous to clk, idle high.
REQ-006 rx_ready  input  1  consumer accepts held word when high with rx_valid.
REQ-007 rx_data  output  7  received data word.
REQ-008 rx_valid  output  1  held word available.
REQ-009 parity_error  output  1  held word failed the even-parity check.
REQ-010 frame_error  output  1  held word had stop bit sampled 0.
REQ-011 overrun  output  1  one-cycle pulse: a completed frame was dropped.

Function
REQ-012 Frame format SHALL be: start 0, data bits d0..d6 LSB first, even-parity bit (XOR of d0..d6), stop 1.
REQ-013 rx_in SHALL pass through a 2-flop synchronizer (rx_s); all logic uses rx_s only.
REQ-014 FSM SHALL have states IDLE, START, DATA, PARITY, STOP, BREAK; one bit counter (0..CLKS_PER_BIT-1) and one 3-bit index.
REQ-015 IDLE: falling edge of rx_s (1 then 0) -> START, counter cleared.
REQ-016 START: at counter == HALF_BIT-1, sample rx_s; 0 -> DATA, counter cleared; 1 -> IDLE (glitch rejected, no output change).
REQ-017 DATA: at counter == CLKS_PER_BIT-1, shift rx_s into bit[index], counter cleared; after index 6 -> PARITY.
REQ-018 PARITY: at counter == CLKS_PER_BIT-1 sample parity bit -> STOP.
REQ-019 STOP: at counter == CLKS_PER_BIT-1 sample stop bit; 1 -> IDLE; 0 -> BREAK.
REQ-020 BREAK: remain until rx_s == 1, then -> IDLE; no new frame is detected in BREAK.
REQ-021 On the stop-sample cycle, if rx_valid is 0 or (rx_valid and rx_ready), the next cycle SHALL load rx_data, parity_error (sampled parity != XOR of data), frame_error (stop == 0) and set rx_valid = 1.
REQ-022 If rx_valid = 1 and rx_ready = 0 on the stop-sample cycle, the new frame SHALL be discarded, held outputs unchanged, overrun pulsed high one cycle.
REQ-023 rx_valid SHALL clear the cycle after rx_valid and rx_ready are both high, unless REQ-021 reloads it in that same cycle (reload wins).
REQ-024 rx_data, parity_error, frame_error SHALL remain stable while rx_valid = 1.
REQ-025 Latency: rx_valid rises 1 cycle after the stop-bit sample, ~(2 + HALF_BIT + 9*CLKS_PER_BIT + 1) cycles after the rx_in falling edge.
REQ-026 Frames with errors SHALL still be delivered via rx_valid with the corresponding flag set.

Reset
REQ-027 rst_n low SHALL force IDLE, counter 0, index 0, synchronizer flops 1, rx_data 0, rx_valid 0, parity_error 0, frame_error 0, overrun 0.
REQ-028 Reset asserted mid-frame SHALL abandon the frame; after release a new frame is detected only on a fresh falling edge.
REQ-029 A line held low across reset release SHALL NOT start a frame until rx_s has been seen high.

Verification
REQ-030 Frame data 7'h7F, parity 1, stop 1, rx_ready = 1 -> rx_valid one cycle, rx_data = 7'h7F, parity_error = 0, frame_error = 0.
REQ-031 Frame data 7'h55, parity 1 (expected 0) -> rx_data = 7'h55, parity_error = 1, frame_error = 0.
REQ-032 rx_in low for 100 cycles then high -> no rx_valid, FSM back in IDLE, next valid frame 7'h2A received correctly.
REQ-033 Frame 7'h01 with stop bit 0, line held low 3 bit times -> rx_valid with frame_error = 1; no second frame while low; frame after line returns high received.
REQ-034 Two back-to-back frames 7'h11 then 7'h22, rx_ready = 0 -> rx_data stays 7'h11, overrun pulses once at second stop sample; then rx_ready = 1 -> rx_valid clears.
REQ-035 rst_n pulsed low during DATA of frame 7'h33 -> all outputs 0, no rx_valid for that frame; following frame 7'h44 received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// 7E1 UART receiver: 2-flop synchronizer, mid-bit sampling FSM and a single-word
// holding register with valid/ready handshake, parity/frame flags and overrun pulse.
module uart_rx #(
   parameter int CLKS_PER_BIT = 521,
   parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx_in,
   input  logic       rx_ready,
   output logic [6:0] rx_data,
   output logic       rx_valid,
   output logic       parity_error,
   output logic       frame_error,
   output logic       overrun
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] MID_CNT  = CW'(HALF_BIT - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic [2:0]    idx;
   logic [6:0]    shreg;
   logic          par_bit;

   logic       rx_meta;
   logic       rx_s;
   logic       rx_prev;
   logic [1:0] fill;

   // rx_prev only tracks rx_s once the synchronizer holds real line samples, so a
   // line already low at reset release is never mistaken for a start edge.
   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
         rx_prev <= 1'b0;
         fill    <= 2'b00;
      end else begin
         rx_meta <= rx_in;
         rx_s    <= rx_meta;
         fill    <= {fill[0], 1'b1};
         rx_prev <= rx_s & fill[1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         cnt          <= '0;
         idx          <= '0;
         shreg        <= '0;
         par_bit      <= 1'b0;
         rx_data      <= '0;
         rx_valid     <= 1'b0;
         parity_error <= 1'b0;
         frame_error  <= 1'b0;
         overrun      <= 1'b0;
      end else begin
         overrun <= 1'b0;
         // NOTE: the handshake clear is written first so a reload in STOP later in
         // this block overrides it in the same cycle (last non-blocking write wins).
         if (rx_valid && rx_ready)
            rx_valid <= 1'b0;

         case (state)
            IDLE: begin
               cnt <= '0;
               idx <= '0;
               if (rx_prev && !rx_s)
                  state <= START;
            end

            START: begin
               if (cnt == MID_CNT) begin
                  cnt   <= '0;
                  state <= rx_s ? IDLE : DATA;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end

            DATA: begin
               if (cnt == LAST_CNT) begin
                  cnt        <= '0;
                  shreg[idx] <= rx_s;
                  if (idx == 3'd6) begin
                     idx   <= '0;
                     state <= PARITY;
                  end else begin
                     idx <= idx + 3'd1;
                  end
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end

            PARITY: begin
               if (cnt == LAST_CNT) begin
                  cnt     <= '0;
                  par_bit <= rx_s;
                  state   <= STOP;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end

            STOP: begin
               if (cnt == LAST_CNT) begin
                  cnt <= '0;
                  if (!rx_valid || rx_ready) begin
                     rx_data      <= shreg;
                     parity_error <= (par_bit != ^shreg);
                     frame_error  <= !rx_s;
                     rx_valid     <= 1'b1;
                  end else begin
                     overrun <= 1'b1;
                  end
                  state <= rx_s ? IDLE : BREAK;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end

            BREAK: begin
               cnt <= '0;
               if (rx_s)
                  state <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule
